// File: rtl/cmd_packet_decoder.sv
// Byte-stream command decoder: assembles an opcode and a big-endian payload into one
// command word and offers it on a valid/ready handshake, with timeout resync and overrun flag.
module cmd_packet_decoder #(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter logic [7:0]  SHORT_MASK     = 8'h80,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       byte_in_ready,
    input  logic [7:0]                 byte_in,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [7:0]                 opcode,
    output logic [8*PAYLOAD_BYTES-1:0] command,
    output logic                       timeout_err,
    output logic                       overrun_err
);

    localparam int unsigned CMD_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [7:0]         r_opcode;
    logic [CMD_W-1:0]   r_command;
    logic               r_cmd_valid;
    logic               r_timeout_err;
    logic               r_overrun_err;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;

    state_t             w_state_nxt;
    logic [7:0]         w_opcode_nxt;
    logic [CMD_W-1:0]   w_command_nxt;
    logic               w_cmd_valid_nxt;
    logic               w_timeout_err_nxt;
    logic               w_overrun_err_nxt;
    logic [CNT_W-1:0]   w_byte_cnt_nxt;
    logic [TMO_W-1:0]   w_tmo_cnt_nxt;
    logic               w_short;

    assign w_short = ((byte_in & SHORT_MASK) == 8'h00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_command     <= '0;
            r_cmd_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
            r_byte_cnt    <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_opcode      <= w_opcode_nxt;
            r_command     <= w_command_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_overrun_err <= w_overrun_err_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_opcode_nxt      = r_opcode;
        w_command_nxt     = r_command;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_timeout_err_nxt = 1'b0;
        w_overrun_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (byte_in_ready) begin
                    w_opcode_nxt   = byte_in;
                    w_command_nxt  = '0;
                    w_byte_cnt_nxt = '0;
                    w_tmo_cnt_nxt  = '0;
                    w_state_nxt    = w_short ? S_HOLD : S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                if (byte_in_ready) begin
                    for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                        if (CNT_W'(k) == r_byte_cnt) begin
                            w_command_nxt[8*(PAYLOAD_BYTES-k)-1 -: 8] = byte_in;
                        end
                    end
                    w_tmo_cnt_nxt = '0;
                    if (r_byte_cnt == CNT_LAST) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                // Counter holds cycles already waited; this cycle is the TIMEOUT_CYCLES-th.
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_timeout_err_nxt = 1'b1;
                    w_opcode_nxt      = '0;
                    w_command_nxt     = '0;
                    w_byte_cnt_nxt    = '0;
                    w_tmo_cnt_nxt     = '0;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end

            S_HOLD: begin
                if (byte_in_ready) begin
                    w_overrun_err_nxt = 1'b1;
                end
                if (r_cmd_valid && cmd_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_valid_nxt = (w_state_nxt == S_HOLD);
    end

    assign cmd_valid   = r_cmd_valid;
    assign opcode      = r_opcode;
    assign command     = r_command;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule
